// File: rtl/msk_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// msk_ctrl_pkg
// Shared definitions for the masked Clyde S-box layer controller.
//   msk_state_e    : controller FSM states (IDLE / RUN / DONE)
//   clog2_min1()   : ceil(log2(n)) clamped to at least 1, for select widths
//   RND_WORD_BITS(): fresh-randomness bits consumed per pipeline advance
//                    for a d-share implementation (PRNG side sizing)
// -----------------------------------------------------------------------------
package msk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } msk_state_e;

    // Number of masked AND gadgets that are active in parallel on every
    // pipeline advance (one per bit of a 32-bit column slice row).
    localparam int ANDS_PER_ADV = 32;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Each d-share gadget needs one fresh bit per share pair.
    function automatic int RND_WORD_BITS(input int d);
        return ANDS_PER_ADV * ((d * (d - 1)) / 2);
    endfunction

endpackage

// File: rtl/msk_pipe_tracker.sv
// -----------------------------------------------------------------------------
// msk_pipe_tracker
// Tracks which slices occupy the masked S-box pipeline and which slice is
// being issued / written back on each pipeline advance.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr          : clear counters and occupancy (start of a layer)
//   adv          : pipeline advances this cycle
//   inject       : new slices may be issued on this advance
//   in_vld/in_sel   : slice entering stage 0 (sel forced to 0 when not valid)
//   out_vld/out_sel : slice written back from the last stage (sel 0 if idle)
//   all_written  : every slice of the layer has been written back
// -----------------------------------------------------------------------------
module msk_pipe_tracker
    import msk_ctrl_pkg::*;
#(
    parameter  int SLICES = 4,
    parameter  int STAGES = 2,
    localparam int SEL_W  = clog2_min1(SLICES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic             inject,
    output logic             in_vld,
    output logic [SEL_W-1:0] in_sel,
    output logic             out_vld,
    output logic [SEL_W-1:0] out_sel,
    output logic             all_written
);

    localparam int                 CNT_W    = clog2_min1(SLICES + 1);
    localparam logic [CNT_W-1:0]   SLICES_C = CNT_W'(SLICES);

    logic [CNT_W-1:0] issued_reg;
    logic [CNT_W-1:0] written_reg;

    // Occupancy as seen after this advance's shift: bit 0 is the slice just
    // entering, bit STAGES-1 is the slice leaving the last stage. The leaving
    // slice is written back on the same advance that loads it into the last
    // stage, so only the first STAGES-1 occupancy bits need to be stored.
    logic [STAGES-1:0] occ_shift;

    assign in_vld  = adv & inject & (issued_reg < SLICES_C);
    assign in_sel  = in_vld ? issued_reg[SEL_W-1:0] : '0;
    assign out_vld = adv & occ_shift[STAGES-1];
    assign out_sel = out_vld ? written_reg[SEL_W-1:0] : '0;

    assign all_written = (written_reg == SLICES_C);

    assign occ_shift[0] = in_vld;

    genvar gi;
    generate
        if (STAGES > 1) begin : g_occ
            logic [STAGES-2:0] occ_reg;

            for (gi = 1; gi < STAGES; gi++) begin : g_tap
                assign occ_shift[gi] = occ_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    occ_reg <= '0;
                end else if (adv) begin
                    occ_reg <= occ_shift[STAGES-2:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            issued_reg  <= '0;
            written_reg <= '0;
        end else begin
            if (in_vld) begin
                issued_reg <= issued_reg + 1'b1;
            end
            if (out_vld) begin
                written_reg <= written_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/msk_sbox_layer_ctrl.sv
// -----------------------------------------------------------------------------
// msk_sbox_layer_ctrl
// Sequencer for the masked bitsliced Clyde S-box layer. Streams SLICES column
// slices through a STAGES-deep masked pipeline; each advance consumes one
// fresh PRNG word over a valid/ready handshake.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request one S-box layer (accepted only in IDLE)
//   busy, done        : layer in progress / one-cycle completion pulse
//   rnd_valid/ready   : PRNG handshake; ready is purely state-derived
//   pipe_en           : global pipeline advance (= rnd_valid & rnd_ready)
//   in_vld/in_sel     : slice entering stage 0 on this advance
//   out_vld/out_sel   : slice written back to the state on this advance
// -----------------------------------------------------------------------------
module msk_sbox_layer_ctrl
    import msk_ctrl_pkg::*;
#(
    parameter  int SLICES = 4,
    parameter  int STAGES = 2,
    localparam int SEL_W  = clog2_min1(SLICES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    output logic             pipe_en,
    output logic             in_vld,
    output logic [SEL_W-1:0] in_sel,
    output logic             out_vld,
    output logic [SEL_W-1:0] out_sel
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(SLICES - 1);

    msk_state_e state_reg;
    msk_state_e state_next;

    logic run;
    logic accept;
    logic last_wb;
    logic all_written;

    assign run       = (state_reg == ST_RUN);
    assign accept    = (state_reg == ST_IDLE) && start;
    assign rnd_ready = run;
    assign busy      = run;
    assign done      = (state_reg == ST_DONE);
    assign pipe_en   = run & rnd_valid;

    // out_vld already implies an advance, so this marks the advance that
    // writes back the final slice of the layer.
    assign last_wb = out_vld && (out_sel == LAST_SEL);

    msk_pipe_tracker #(
        .SLICES (SLICES),
        .STAGES (STAGES)
    ) u_tracker (
        .clk         (clk),
        .rst         (rst),
        .clr         (accept),
        .adv         (pipe_en),
        .inject      (run),
        .in_vld      (in_vld),
        .in_sel      (in_sel),
        .out_vld     (out_vld),
        .out_sel     (out_sel),
        .all_written (all_written)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            // all_written is a safety exit; the normal exit is last_wb.
            ST_RUN:  if (last_wb || all_written) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

endmodule

// File: tb/tb_msk_sbox_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_msk_sbox_layer_ctrl
// Directed bench for msk_sbox_layer_ctrl: a SLICES=4/STAGES=2 instance (u0)
// and a SLICES=1/STAGES=1 instance (u1) sharing clock, reset and inputs.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 4 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_msk_sbox_layer_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic rnd_valid;

    logic       busy0, done0, rdy0, pe0, iv0, ov0;
    logic [1:0] is0, os0;
    logic       busy1, done1, rdy1, pe1, iv1, ov1;
    logic [0:0] is1, os1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    msk_sbox_layer_ctrl #(.SLICES(4), .STAGES(2)) u0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy0), .done(done0),
        .rnd_valid(rnd_valid), .rnd_ready(rdy0), .pipe_en(pe0),
        .in_vld(iv0), .in_sel(is0), .out_vld(ov0), .out_sel(os0)
    );

    msk_sbox_layer_ctrl #(.SLICES(1), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy1), .done(done1),
        .rnd_valid(rnd_valid), .rnd_ready(rdy1), .pipe_en(pe1),
        .in_vld(iv1), .in_sel(is1), .out_vld(ov1), .out_sel(os1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed view: {busy,done,rnd_ready,pipe_en,in_vld,in_sel,out_vld,out_sel}
    function automatic logic [31:0] p0();
        return {22'd0, busy0, done0, rdy0, pe0, iv0, is0, ov0, os0};
    endfunction

    function automatic logic [31:0] p1();
        return {24'd0, busy1, done1, rdy1, pe1, iv1, is1, ov1, os1};
    endfunction

    function automatic logic [31:0] e0(input logic b, input logic d, input logic r,
                                       input logic p, input logic iv, input int isel,
                                       input logic ov, input int osel);
        logic [1:0] is_v;
        logic [1:0] os_v;
        is_v = 2'(isel);
        os_v = 2'(osel);
        return {22'd0, b, d, r, p, iv, is_v, ov, os_v};
    endfunction

    function automatic logic [31:0] e1(input logic b, input logic d, input logic r,
                                       input logic p, input logic iv, input logic ov);
        return {24'd0, b, d, r, p, iv, 1'b0, ov, 1'b0};
    endfunction

    // One clock cycle: drive inputs just after the edge, then settle.
    task automatic cyc(input logic st, input logic rv, input logic r);
        @(posedge clk);
        #1;
        start     = st;
        rnd_valid = rv;
        rst       = r;
        #3;
    endtask

    // Cycles 1..6 of an uninterrupted layer on u0 (start already issued in
    // cycle 0, rnd_valid held high). Returns number of done pulses seen.
    task automatic full_run(input string tag, output int dones);
        dones = 0;
        for (int c = 1; c <= 5; c++) begin
            logic iv;
            logic ov;
            cyc(1'b0, 1'b1, 1'b0);
            iv = (c <= 4);
            ov = (c >= 2);
            dones += int'(done0);
            chk($sformatf("%s_c%0d", tag, c), p0(),
                e0(1, 0, 1, 1, iv, iv ? c - 1 : 0, ov, ov ? c - 2 : 0));
        end
        cyc(1'b0, 1'b1, 1'b0);
        dones += int'(done0);
        chk($sformatf("%s_c6_done", tag), p0(), e0(0, 1, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        int dones;
        int hs;
        int exp_in;
        int exp_out;
        int cnt;
        bit seen_done;

        start = 1'b0; rnd_valid = 1'b0; rst = 1'b1;

        // ---- reset state
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("reset_u0", p0(), 32'd0);
        chk("reset_u1", p1(), 32'd0);

        // ---- 1: nominal layer (u0), plus SLICES=1/STAGES=1 (u1)
        cyc(1'b1, 1'b1, 1'b0);
        chk("t1_c0", p0(), 32'd0);
        chk("t5_c0", p1(), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t1_c1", p0(), e0(1, 0, 1, 1, 1, 0, 0, 0));
        chk("t5_c1", p1(), e1(1, 0, 1, 1, 1, 1));
        cyc(1'b0, 1'b1, 1'b0);
        chk("t1_c2", p0(), e0(1, 0, 1, 1, 1, 1, 1, 0));
        chk("t5_c2_done", p1(), e1(0, 1, 0, 0, 0, 0));
        cyc(1'b0, 1'b1, 1'b0);
        chk("t1_c3", p0(), e0(1, 0, 1, 1, 1, 2, 1, 1));
        chk("t5_c3_idle", p1(), 32'd0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t1_c4", p0(), e0(1, 0, 1, 1, 1, 3, 1, 2));
        cyc(1'b0, 1'b1, 1'b0);
        chk("t1_c5", p0(), e0(1, 0, 1, 1, 0, 0, 1, 3));
        cyc(1'b0, 1'b1, 1'b0);
        chk("t1_c6_done", p0(), e0(0, 1, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, 1'b1, 1'b0);
        chk("t1_c7_idle", p0(), 32'd0);

        // ---- 2: randomness stall in cycles 3..5
        cyc(1'b1, 1'b1, 1'b0);
        hs = 0;
        for (int c = 1; c <= 9; c++) begin
            logic [31:0] exp;
            cyc(1'b0, (c >= 3 && c <= 5) ? 1'b0 : 1'b1, 1'b0);
            hs += int'(pe0);
            case (c)
                1:       exp = e0(1, 0, 1, 1, 1, 0, 0, 0);
                2:       exp = e0(1, 0, 1, 1, 1, 1, 1, 0);
                6:       exp = e0(1, 0, 1, 1, 1, 2, 1, 1);
                7:       exp = e0(1, 0, 1, 1, 1, 3, 1, 2);
                8:       exp = e0(1, 0, 1, 1, 0, 0, 1, 3);
                9:       exp = e0(0, 1, 0, 0, 0, 0, 0, 0);
                default: exp = e0(1, 0, 1, 0, 0, 0, 0, 0);
            endcase
            chk($sformatf("t2_c%0d", c), p0(), exp);
        end
        chk("t2_handshakes", hs, 5);
        cyc(1'b0, 1'b0, 1'b0);

        // ---- 3: extra starts while busy and in DONE are ignored
        cyc(1'b1, 1'b1, 1'b0);
        dones = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc((c == 3 || c == 6) ? 1'b1 : 1'b0, 1'b1, 1'b0);
            dones += int'(done0);
            if (c == 3) chk("t3_c3", p0(), e0(1, 0, 1, 1, 1, 2, 1, 1));
            if (c == 6) chk("t3_c6_done", p0(), e0(0, 1, 0, 0, 0, 0, 0, 0));
            if (c == 8) chk("t3_c8_idle", p0(), 32'd0);
        end
        chk("t3_done_count", dones, 1);

        // ---- 4: reset in cycle 3 of a run, then a fresh layer
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        cnt = int'(done0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t4_c4_reset", p0(), 32'd0);
        cnt += int'(done0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t4_c5_idle", p0(), 32'd0);
        full_run("t4", dones);
        chk("t4_done_count", cnt + dones, 1);
        cyc(1'b0, 1'b0, 1'b0);

        // ---- 6: random rnd_valid over 1000 layers
        for (int layer = 0; layer < 1000; layer++) begin
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            chk("t6_idle_no_adv", {31'd0, pe0}, 32'd0);
            hs = 0; exp_in = 0; exp_out = 0; seen_done = 1'b0;
            for (int c = 0; c < 400 && !seen_done; c++) begin
                cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
                if (pe0 && !busy0) chk("t6_adv_outside_run", {31'd0, pe0}, 32'd0);
                hs += int'(pe0);
                if (iv0) begin
                    chk("t6_in_sel", {30'd0, is0}, exp_in);
                    exp_in++;
                end
                if (ov0) begin
                    chk("t6_out_sel", {30'd0, os0}, exp_out);
                    exp_out++;
                end
                if (done0) seen_done = 1'b1;
            end
            chk("t6_done_seen", {31'd0, seen_done}, 32'd1);
            chk("t6_handshakes", hs, 5);
            chk("t6_issued", exp_in, 4);
            chk("t6_written", exp_out, 4);
            if (!seen_done) break;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
